// File: rtl/uart_hex_tx.sv
// uart_hex_tx
//   Prints a binary word as uppercase ASCII hex, optionally followed by
//   CR LF, by strobing one character at a time into a downstream uart_tx.
//
// Parameters
//   DIGITS  : hex digits per word (1..8); input word is 4*DIGITS bits wide
//   NEWLINE : 1 appends 0x0D 0x0A after the digits, 0 appends nothing
//
// Ports
//   clk         : system clock
//   reset       : synchronous, active-high reset
//   in_data     : word to print
//   in_valid    : in_data is valid
//   in_ready    : block can accept a word (IDLE and not in reset)
//   uart_data   : character presented to uart_tx (valid while uart_strobe=1)
//   uart_strobe : one-cycle pulse to uart_tx data_strobe
//   uart_ready  : ready from uart_tx
//   busy        : a line is in progress
module uart_hex_tx #(
    parameter int DIGITS  = 8,
    parameter int NEWLINE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            uart_data,
    output logic                  uart_strobe,
    input  logic                  uart_ready,
    output logic                  busy
);

    localparam int         W          = 4 * DIGITS;
    localparam int         TOTAL      = DIGITS + 2 * NEWLINE;
    localparam logic [3:0] DIGITS_IDX = 4'(DIGITS);
    localparam logic [3:0] TOTAL_IDX  = 4'(TOTAL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   shift_q, shift_d;
    logic [3:0]     idx_q, idx_d;
    logic [7:0]     data_q, data_d;
    logic           strobe_q, strobe_d;
    logic [7:0]     cur_char_s;

    // Map a nibble to its uppercase ASCII hex digit.
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        logic [7:0] c;
        if (nib < 4'd10) begin
            c = 8'h30 + {4'h0, nib};
        end else begin
            c = 8'h37 + {4'h0, nib};
        end
        return c;
    endfunction

    // Character selected by the current index: digits come from the top
    // nibble of the shift register, then CR, then LF.
    always_comb begin
        cur_char_s = 8'h00;
        if (idx_q < DIGITS_IDX) begin
            cur_char_s = hex_char(shift_q[W-1 -: 4]);
        end else if (idx_q == DIGITS_IDX) begin
            cur_char_s = 8'h0D;
        end else begin
            cur_char_s = 8'h0A;
        end
    end

    // Next-state and datapath updates for the IDLE/SEND/GUARD sequencer.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = in_data;
                    idx_d   = 4'd0;
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (uart_ready) begin
                    data_d   = cur_char_s;
                    strobe_d = 1'b1;
                    idx_d    = idx_q + 4'd1;
                    // Shifting past the digits is harmless: only CR/LF remain.
                    shift_d  = shift_q << 3'd4;
                    state_d  = GUARD;
                end else begin
                    state_d = SEND;
                end
            end
            GUARD: begin
                // uart_tx only drops ready the cycle after a strobe, so this
                // cycle's uart_ready is stale and deliberately not looked at.
                if (idx_q == TOTAL_IDX) begin
                    state_d = IDLE;
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= 4'd0;
            data_q   <= 8'h00;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
        end
    end

    assign in_ready    = (state_q == IDLE) && !reset;
    assign busy        = (state_q != IDLE) && !reset;
    assign uart_data   = data_q;
    assign uart_strobe = strobe_q;

endmodule
